// File: rtl/address_select_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | addr_arb_pkg : shared types and decode helper for the arbiter slice   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package addr_arb_pkg;

  // Widest per-requester address the onehot helper can expand.
  localparam int unsigned ADDR_MAX_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  function automatic logic [2**ADDR_MAX_W-1:0] onehot(input logic [ADDR_MAX_W-1:0] addr);
    logic [2**ADDR_MAX_W-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/address_select_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | address_select_arbiter_if : requester/decoder bundle of the arbiter   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface address_select_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 1
) ();

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ-1:0]        grant;
  logic                      enable;
  logic [ADDR_W-1:0]         to_decode;
  logic [2**ADDR_W-1:0]      decoded;
  logic                      done;
  logic                      busy;

  modport master (
    output req, req_addr, lock,
    input  grant, enable, to_decode, decoded, done, busy
  );

  modport slave (
    input  req, req_addr, lock,
    output grant, enable, to_decode, decoded, done, busy
  );

endinterface
`default_nettype wire

// File: rtl/address_select_arbiter_rr_pick.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_pick : combinational round-robin picker, search upward from ptr    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module rr_pick
  import addr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         winner,
  output logic [$clog2(NUM_REQ)-1:0] win_idx,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    winner  = '0;
    win_idx = '0;
    any     = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Modular wrap that also works for non power-of-two NUM_REQ.
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!any && req[cand]) begin
        any          = 1'b1;
        win_idx      = cand;
        winner[cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/address_select_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | address_select_arbiter : round-robin owner of one address decoder;    |
// | sequences SETUP/ACCESS/RELEASE. ARB_LOCK_EN enables locked re-grant.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module address_select_arbiter
  import addr_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 1,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  address_select_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int DEC_W = 2**ADDR_W;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic                 full_q, full_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [ADDR_W-1:0]    to_decode_q, to_decode_d;
  logic                 enable_q, enable_d;
  logic [DEC_W-1:0]     decoded_q, decoded_d;
  logic                 done_q, done_d;

  logic [NUM_REQ-1:0]   w_pick_onehot;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_pick_any;
  logic [ADDR_W-1:0]    w_pick_addr;
  logic [ADDR_W-1:0]    w_granted_addr;
  logic                 w_granted_req;
  logic                 w_relock;
  logic [IDX_W-1:0]     w_ptr_next;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .winner  (w_pick_onehot),
    .win_idx (w_pick_idx),
    .any     (w_pick_any)
  );

  assign w_pick_addr    = bus.req_addr[int'(w_pick_idx)*ADDR_W +: ADDR_W];
  assign w_granted_addr = bus.req_addr[int'(grant_idx_q)*ADDR_W +: ADDR_W];
  assign w_granted_req  = bus.req[grant_idx_q];
  assign w_ptr_next     = (grant_idx_q == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx_q + IDX_W'(1);

`ifdef ARB_LOCK_EN
  assign w_relock = bus.lock[grant_idx_q] & w_granted_req;
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
  assign w_relock    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    hold_cnt_d  = hold_cnt_q;
    full_d      = full_q;
    grant_d     = grant_q;
    to_decode_d = to_decode_q;

    case (state_q)
      IDLE: begin
        if (w_pick_any) begin
          state_d     = SETUP;
          grant_d     = w_pick_onehot;
          grant_idx_d = w_pick_idx;
          to_decode_d = w_pick_addr;
          hold_cnt_d  = '0;
          full_d      = 1'b0;
        end
      end
      SETUP: begin
        if (!w_granted_req) begin
          state_d = RELEASE;
          full_d  = 1'b0;
        end else begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Abort wins over completion on the final hold cycle.
        if (!w_granted_req) begin
          state_d = RELEASE;
          full_d  = 1'b0;
        end else if (hold_cnt_q == CNT_W'(HOLD_CYCLES-1)) begin
          state_d = RELEASE;
          full_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (w_relock) begin
          state_d     = SETUP;
          to_decode_d = w_granted_addr;
          hold_cnt_d  = '0;
          full_d      = 1'b0;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = w_ptr_next;
          full_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    enable_d  = (state_d == ACCESS);
    decoded_d = enable_d ? DEC_W'(onehot(ADDR_MAX_W'(to_decode_d))) : '0;
    done_d    = (state_d == RELEASE) && full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_idx_q <= '0;
      hold_cnt_q  <= '0;
      full_q      <= 1'b0;
      grant_q     <= '0;
      to_decode_q <= '0;
      enable_q    <= 1'b0;
      decoded_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      full_q      <= full_d;
      grant_q     <= grant_d;
      to_decode_q <= to_decode_d;
      enable_q    <= enable_d;
      decoded_q   <= decoded_d;
      done_q      <= done_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.enable    = enable_q;
  assign bus.to_decode = to_decode_q;
  assign bus.decoded   = decoded_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_address_select_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_address_select_arbiter : directed vectors for the address arbiter  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_address_select_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  address_select_arbiter_if #(.NUM_REQ(4), .ADDR_W(1)) bus ();

  address_select_arbiter #(
    .NUM_REQ     (4),
    .ADDR_W      (1),
    .HOLD_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] addr;
    logic [3:0] grant;
    logic       en;
    logic       td;
    logic [1:0] dec;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t tbl [0:22];

  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] ad, input logic [3:0] lk);
    rst          = r;
    bus.req      = rq;
    bus.req_addr = ad;
    bus.lock     = lk;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input int step, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] %s: got %0h want %0h", tag, step, field, act, exp);
    end
  endtask

  task automatic check(input string tag, input int step, input logic [3:0] g, input logic en,
                       input logic td, input logic [1:0] dec, input logic done, input logic busy);
    cmp(tag, step, "grant",     32'(bus.grant),     32'(g));
    cmp(tag, step, "enable",    32'(bus.enable),    32'(en));
    cmp(tag, step, "to_decode", 32'(bus.to_decode), 32'(td));
    cmp(tag, step, "decoded",   32'(bus.decoded),   32'(dec));
    cmp(tag, step, "done",      32'(bus.done),      32'(done));
    cmp(tag, step, "busy",      32'(bus.busy),      32'(busy));
  endtask

  logic [3:0] rr_exp [0:4];
  logic [3:0] prev_grant;
  int         ev_cnt;
  int         done_cnt;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req = '0;
    bus.req_addr = '0;
    bus.lock = '0;

    // rst, req, addr -> grant, en, td, dec, done, busy (sampled after the edge)
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
    // non-granted address bits toggle while requester 1 is served
    tbl[6]  = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 4'b0010, 4'b1101, 4'b0010, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 4'b0010, 4'b0001, 4'b0010, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 4'b0010, 4'b1101, 4'b0010, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    // requester 2 drops in its first ACCESS cycle; 3 follows
    tbl[11] = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 4'b1000, 4'b0100, 4'b0100, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1};
    // reset mid-access, then the search restarts from requester 0
    tbl[17] = '{1'b1, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 4'b1100, 4'b0100, 4'b0100, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 4'b1100, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 4'b1100, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
    tbl[21] = '{1'b0, 4'b1100, 4'b0100, 4'b0100, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1};
    tbl[22] = '{1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].addr, 4'b0000);
      check("vec", i, tbl[i].grant, tbl[i].en, tbl[i].td, tbl[i].dec, tbl[i].done, tbl[i].busy);
    end

    // All four requesting continuously: strict rotation, one grant every 5 clocks.
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    drive(1'b1, 4'b0000, 4'b0000, 4'b0000);
    prev_grant = '0;
    ev_cnt     = 0;
    done_cnt   = 0;
    for (int s = 1; s <= 25; s++) begin
      drive(1'b0, 4'b1111, 4'b1010, 4'b0000);
      if (bus.done === 1'b1) done_cnt++;
      if (bus.grant !== 4'b0000 && prev_grant === 4'b0000) begin
        if (ev_cnt < 5) begin
          cmp("rr_grant", ev_cnt, "grant", 32'(bus.grant), 32'(rr_exp[ev_cnt]));
          cmp("rr_cycle", ev_cnt, "step", 32'(s), 32'(1 + 5*ev_cnt));
        end
        ev_cnt++;
      end
      prev_grant = bus.grant;
    end
    cmp("rr", 0, "grants", 32'(ev_cnt), 32'd5);
    cmp("rr", 0, "dones", 32'(done_cnt), 32'd5);

    // Lock on requester 2 with requester 0 also pending.
    drive(1'b1, 4'b0000, 4'b0000, 4'b0000);
    check("lock", 0, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) drive(1'b0, 4'b0010, 4'b0000, 4'b0000);
    drive(1'b0, 4'b0000, 4'b0000, 4'b0000);
    drive(1'b0, 4'b0101, 4'b0100, 4'b0100);
    check("lock", 6, 4'b0100, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1);
    drive(1'b0, 4'b0101, 4'b0100, 4'b0100);
    drive(1'b0, 4'b0101, 4'b0100, 4'b0100);
    drive(1'b0, 4'b0101, 4'b0100, 4'b0100);
    check("lock", 9, 4'b0100, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1);
    drive(1'b0, 4'b0101, 4'b0000, 4'b0100);
`ifdef ARB_LOCK_EN
    check("lock", 10, 4'b0100, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    drive(1'b0, 4'b0101, 4'b0000, 4'b0000);
    check("lock", 11, 4'b0100, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
    drive(1'b0, 4'b0101, 4'b0000, 4'b0000);
    drive(1'b0, 4'b0101, 4'b0000, 4'b0000);
    check("lock", 13, 4'b0100, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    drive(1'b0, 4'b0101, 4'b0000, 4'b0000);
    check("lock", 14, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b0, 4'b0101, 4'b0000, 4'b0000);
    check("lock", 15, 4'b0001, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
`else
    check("lock", 10, 4'b0000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    drive(1'b0, 4'b0101, 4'b0000, 4'b0100);
    check("lock", 11, 4'b0001, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/address_select_arbiter.md
# address_select_arbiter

Round-robin arbiter that shares one address-select decoder among several requesters. It grants one requester at a time, registers that requester's address, and sequences the decoder through setup, enabled access and release phases. It drives a one-hot select bus sized for the full address space. It sits between bus masters and the decoded select lines, in front of the 1-bit/n-bit address decode chain.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; must be ≥2.
- ADDR_W, 1: address width per requester. The select bus is 2**ADDR_W wide.
- HOLD_CYCLES, 2: cycles Enable stays high per access; must be ≥1.

Ports:
- Clock  in  1  single clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high.
- Req  in  NUM_REQ  request, one bit per requester; level-sensitive.
- ReqAddr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- Lock  in  NUM_REQ  per-requester lock request; used only with ARB_LOCK_EN.
- Grant  out  NUM_REQ  one-hot grant; all-zero when idle.
- Enable  out  1  decoder enable.
- ToDecode  out  ADDR_W  registered address of the granted requester.
- Decoded  out  2**ADDR_W  one-hot select, equal to onehot(ToDecode) while Enable=1, else zero.
- Done  out  1  single-cycle pulse when an access completes its full hold.
- Busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SETUP, ACCESS, RELEASE.
- IDLE:
  - If any Req bit is high, pick the first set bit searching upward from Ptr, wrapping past NUM_REQ-1 to 0.
  - Register Grant and ToDecode = ReqAddr of the winner, then go to SETUP.
  - With no requests, stay in IDLE.
- SETUP: held for 1 cycle. Enable=0, address stable. Go to ACCESS.
- ACCESS:
  - Enable=1 and Decoded is valid.
  - HoldCnt counts 0..HOLD_CYCLES-1; at the last count go to RELEASE with full=1.
- RELEASE: held for 1 cycle.
  - Enable=0, Decoded=0, and Done=full.
  - Ptr = granted index + 1 (mod NUM_REQ).
  - Grant clears at exit, then return to IDLE.
- Abort: if the granted requester drops Req during SETUP or ACCESS, the next state is RELEASE with full=0, so Done stays 0. Ptr still advances.
- Req and address changes from non-granted requesters are ignored until IDLE. ToDecode never changes while Busy=1.
- Reset values:
  - State=IDLE, Ptr=0, HoldCnt=0.
  - Grant=0, Enable=0, ToDecode=0, Decoded=0, Done=0, Busy=0.
- Reset asserted mid-access forces all of the above on the next edge. No Done is emitted.
- HoldCnt width is $clog2(HOLD_CYCLES+1) bits. It is cleared on entry to SETUP.

## Timing
- Req first seen in IDLE at cycle t:
  - Grant and Busy at t+1 (SETUP).
  - Enable for cycles t+2 .. t+1+HOLD_CYCLES.
  - Done at t+2+HOLD_CYCLES.
  - IDLE at t+3+HOLD_CYCLES.
- Back-to-back service: each requester cycle is 3+HOLD_CYCLES clocks (IDLE, SETUP, HOLD, RELEASE).
- Decoded, Grant, ToDecode and Enable are all registered outputs. There is no combinational path from Req to any output.

## Configuration
- ARB_LOCK_EN defined:
  - In RELEASE, if the granted Lock bit and Req bit are both high, the next state is SETUP with the same Grant, skipping IDLE.
  - ToDecode is re-sampled and Ptr does not advance.
  - Done still pulses per completed access.
- ARB_LOCK_EN undefined: the Lock port is ignored and every grant returns through IDLE.

## Structure
- Package addr_arb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RELEASE);
  - the onehot decode function (ADDR_W in, 2**ADDR_W out).
- One sub-module, rr_pick: a combinational round-robin picker with inputs Req and Ptr, and outputs a one-hot winner, its index, and an any flag.
- The FSM, counter and output registers live in the top level.

## Test plan
- Reset, then Req=0001 with ReqAddr[0]=1, HOLD_CYCLES=2 → Grant=0001 at t+1; Enable and Decoded=10 at t+2 and t+3; Done at t+4; Busy=0 at t+5.
- Req=1111 held continuously → grants in order 0001, 0010, 0100, 1000, 0001, each 5 clocks apart. Exactly one Done per grant.
- Granted requester drops Req during the first ACCESS cycle → RELEASE next cycle with Done=0; the next requester is granted afterwards.
- Reset asserted during ACCESS → next cycle all outputs are 0 and State=IDLE. After release, Req=0100 is granted first (Ptr=0 search).
- Non-granted ReqAddr toggling during ACCESS → ToDecode and Decoded stay unchanged.
- ARB_LOCK_EN with Lock[2]=1, Req[2]=1, Req[0]=1 → requester 2 regranted from RELEASE straight to SETUP. After Lock[2] drops, requester 0 is granted next.
